// File: rtl/fifo_unpack3.sv
// fifo_unpack3: pulls one 96-bit {c, b, a} entry from an upstream first/deq FIFO and emits
// it downstream as three consecutive 32-bit words (a, b, c), one per cycle when unstalled.
// The next entry is popped in the same cycle word c is accepted, so streaming has no bubble.
// A free-running count of accepted downstream words is kept for debug.
module fifo_unpack3 (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [95:0] in_first_i,
    input  logic        in_first_rdy_i,
    input  logic        in_deq_rdy_i,
    output logic        in_deq_ena_o,
    output logic        out_enq_ena_o,
    output logic [31:0] out_enq_v_o,
    input  logic        out_enq_rdy_i,
    output logic        busy,
    output logic [31:0] wordCount
);

    localparam int unsigned FieldW = 32;
    localparam logic [1:0]  IdxA   = 2'd0;
    localparam logic [1:0]  IdxB   = 2'd1;
    localparam logic [1:0]  IdxC   = 2'd2;

    logic [95:0]       hold_q, hold_d;
    logic [1:0]        idx_q, idx_d;
    logic              full_q, full_d;
    logic [31:0]       word_count_q, word_count_d;

    logic              accept;
    logic              last;
    logic              load;

    // Handshake decode: a word leaves when held and downstream is ready; a new entry may be
    // captured when empty, or when the final word of the current entry leaves this cycle.
    always_comb begin
        accept = full_q & out_enq_rdy_i;
        last   = accept & (idx_q == IdxC);
        // Gating with nRST keeps upstream untouched while the block is held in reset.
        load   = nRST & in_first_rdy_i & in_deq_rdy_i & (~full_q | last);
    end

    // Next-state for the held entry, field index, valid flag and word counter.
    always_comb begin
        hold_d       = hold_q;
        idx_d        = idx_q;
        full_d       = full_q;
        word_count_d = word_count_q;

        if (accept) begin
            word_count_d = word_count_q + 32'd1;
            if (idx_q == IdxA || idx_q == IdxB) begin
                idx_d = idx_q + 2'd1;
            end else begin
                // Word c (or the unreachable index 3) retires the entry.
                full_d = 1'b0;
                idx_d  = IdxA;
            end
        end

        // A load overrides the retire above when c leaves with a new entry waiting.
        if (load) begin
            hold_d = in_first_i;
            idx_d  = IdxA;
            full_d = 1'b1;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            hold_q       <= '0;
            idx_q        <= IdxA;
            full_q       <= 1'b0;
            word_count_q <= '0;
        end else begin
            hold_q       <= hold_d;
            idx_q        <= idx_d;
            full_q       <= full_d;
            word_count_q <= word_count_d;
        end
    end

    // Field select for the downstream word; index 3 should never occur and yields zero.
    always_comb begin
        out_enq_v_o = '0;
        unique case (idx_q)
            IdxA:    out_enq_v_o = hold_q[0*FieldW +: FieldW];
            IdxB:    out_enq_v_o = hold_q[1*FieldW +: FieldW];
            IdxC:    out_enq_v_o = hold_q[2*FieldW +: FieldW];
            default: out_enq_v_o = '0;
        endcase
    end

    // Remaining outputs are direct views of state and the load decision.
    always_comb begin
        in_deq_ena_o  = load;
        out_enq_ena_o = full_q;
        busy          = full_q;
        wordCount     = word_count_q;
    end

endmodule

// File: tb/tb_fifo_unpack3.sv
// Bench for fifo_unpack3: a word-queue reference model checked every cycle, plus directed
// scenarios with literal expectations (reset, single entry, streaming, stall, reset, wrap).
module tb_fifo_unpack3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [95:0] in_first;
    logic        in_first_rdy;
    logic        in_deq_rdy;
    logic        deq_ena;
    logic        enq_ena;
    logic [31:0] enq_v;
    logic        enq_rdy;
    logic        busy;
    logic [31:0] wc;

    fifo_unpack3 dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .in_first_i     (in_first),
        .in_first_rdy_i (in_first_rdy),
        .in_deq_rdy_i   (in_deq_rdy),
        .in_deq_ena_o   (deq_ena),
        .out_enq_ena_o  (enq_ena),
        .out_enq_v_o    (enq_v),
        .out_enq_rdy_i  (enq_rdy),
        .busy           (busy),
        .wordCount      (wc)
    );

    always #5 CLK = ~CLK;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    // Reference model: pending downstream words of the held entry, and the word counter.
    logic [31:0] m_q[$];
    logic [31:0] m_cnt = '0;
    logic        chk_en = 1'b0;
    logic        preload_req = 1'b0;

    // Observed accepted words with the cycle number they were taken in.
    logic [31:0] got[$];
    int          acc_cyc[$];
    int          cyc_n = 0;

    // Upstream FIFO emulation.
    logic [95:0] up_q[$];
    logic        pop_now;
    int          n_pops = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    task automatic drive_up();
        in_first_rdy = (up_q.size() != 0);
        in_first     = (up_q.size() != 0) ? up_q[0] : 96'h0;
    endtask

    // Call after a negedge: sample the pop decision, advance one clock, update upstream.
    task automatic step();
        pop_now = deq_ena;
        @(posedge CLK);
        #1;
        if (pop_now === 1'b1 && up_q.size() != 0) begin
            void'(up_q.pop_front());
            n_pops++;
        end
        drive_up();
    endtask

    task automatic cyc();
        @(negedge CLK);
        step();
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        up_q.delete();
        drive_up();
        cyc();
        cyc();
        nRST = 1'b1;
        got.delete();
        acc_cyc.delete();
        n_pops = 0;
    endtask

    function automatic logic [95:0] ent(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return {c, b, a};
    endfunction

    // Model update on each rising edge, using the inputs as they stood before the edge.
    always @(posedge CLK) begin
        logic ld;
        cyc_n++;
        if (nRST !== 1'b1) begin
            m_q.delete();
            m_cnt = '0;
        end else if (preload_req) begin
            m_cnt = 32'hFFFF_FFFE;
        end else begin
            ld = in_first_rdy && in_deq_rdy &&
                 (m_q.size() == 0 || (m_q.size() == 1 && enq_rdy));
            if (m_q.size() != 0 && enq_rdy) begin
                got.push_back(enq_v);
                acc_cyc.push_back(cyc_n);
                void'(m_q.pop_front());
                m_cnt = m_cnt + 32'd1;
            end
            if (ld) begin
                m_q.push_back(in_first[31:0]);
                m_q.push_back(in_first[63:32]);
                m_q.push_back(in_first[95:64]);
            end
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge CLK) begin
        logic exp_deq;
        if (chk_en) begin
            exp_deq = nRST && in_first_rdy && in_deq_rdy &&
                      (m_q.size() == 0 || (m_q.size() == 1 && enq_rdy));
            chk1("m_deq_ena", deq_ena, exp_deq);
            chk1("m_enq_ena", enq_ena, m_q.size() != 0);
            chk1("m_busy", busy, m_q.size() != 0);
            chk32("m_wordCount", wc, m_cnt);
            if (m_q.size() != 0) chk32("m_enq_v", enq_v, m_q[0]);
        end
    end

    logic [31:0] exp_stream[12];

    initial begin
        nRST       = 1'b0;
        in_deq_rdy = 1'b1;
        enq_rdy    = 1'b1;
        up_q.delete();
        up_q.push_back(ent(32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003));
        drive_up();
        @(posedge CLK);
        #1;
        chk_en = 1'b1;

        // Reset held with upstream ready: nothing pops, nothing emitted.
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk1("rst_deq_ena", deq_ena, 1'b0);
            chk1("rst_enq_ena", enq_ena, 1'b0);
            chk32("rst_wordCount", wc, 32'h0);
            if (i == 0) chk32("rst_enq_v", enq_v, 32'h0);
            step();
        end
        up_q.delete();
        drive_up();
        nRST = 1'b1;
        got.delete();

        // Single entry.
        up_q.push_back(ent(32'h1111_1111, 32'h2222_2222, 32'h3333_3333));
        drive_up();
        @(negedge CLK);
        chk1("single_pop", deq_ena, 1'b1);
        step();
        for (int i = 0; i < 5; i++) cyc();
        @(negedge CLK);
        chk32("single_count", got.size(), 32'd3);
        if (got.size() == 3) begin
            chk32("single_a", got[0], 32'h1111_1111);
            chk32("single_b", got[1], 32'h2222_2222);
            chk32("single_c", got[2], 32'h3333_3333);
            chk32("single_contig", acc_cyc[2] - acc_cyc[0], 32'd2);
        end
        chk1("single_idle_ena", enq_ena, 1'b0);
        chk32("single_wc", wc, 32'd3);
        step();

        // Streaming four entries.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            up_q.push_back(ent(32'hA000_0000 + k, 32'hB000_0000 + k, 32'hC000_0000 + k));
        end
        drive_up();
        exp_stream = '{32'hA000_0000, 32'hB000_0000, 32'hC000_0000,
                       32'hA000_0001, 32'hB000_0001, 32'hC000_0001,
                       32'hA000_0002, 32'hB000_0002, 32'hC000_0002,
                       32'hA000_0003, 32'hB000_0003, 32'hC000_0003};
        for (int i = 0; i < 40 && got.size() < 12; i++) cyc();
        chk32("stream_count", got.size(), 32'd12);
        if (got.size() == 12) begin
            for (int i = 0; i < 12; i++) chk32("stream_word", got[i], exp_stream[i]);
            chk32("stream_contig", acc_cyc[11] - acc_cyc[0], 32'd11);
        end
        chk32("stream_pops", n_pops, 32'd4);
        @(negedge CLK);
        chk32("stream_wc", wc, 32'd12);
        step();

        // Backpressure while b is presented.
        do_reset();
        up_q.push_back(ent(32'h0A0A_0A0A, 32'h0B0B_0B0B, 32'h0C0C_0C0C));
        drive_up();
        cyc();                       // pop edge
        cyc();                       // a accepted
        enq_rdy = 1'b0;
        up_q.push_back(ent(32'h1A1A_1A1A, 32'h1B1B_1B1B, 32'h1C1C_1C1C));
        drive_up();
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk32("stall_v", enq_v, 32'h0B0B_0B0B);
            chk1("stall_nopop", deq_ena, 1'b0);
            chk1("stall_ena", enq_ena, 1'b1);
            step();
        end
        enq_rdy = 1'b1;
        for (int i = 0; i < 20 && got.size() < 6; i++) cyc();
        chk32("stall_count", got.size(), 32'd6);
        if (got.size() == 6) begin
            chk32("stall_w1", got[1], 32'h0B0B_0B0B);
            chk32("stall_w2", got[2], 32'h0C0C_0C0C);
            chk32("stall_w3", got[3], 32'h1A1A_1A1A);
        end

        // Reset in the middle of an entry.
        do_reset();
        up_q.push_back(ent(32'h5555_0001, 32'h5555_0002, 32'h5555_0003));
        drive_up();
        cyc();                       // pop edge
        cyc();                       // a accepted
        nRST = 1'b0;
        cyc();
        nRST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk1("midrst_ena", enq_ena, 1'b0);
            chk1("midrst_busy", busy, 1'b0);
            step();
        end
        chk32("midrst_count", got.size(), 32'd1);

        // Counter wrap from a preloaded value.
        do_reset();
        chk_en      = 1'b0;
        preload_req = 1'b1;
        force dut.word_count_q = 32'hFFFF_FFFE;
        @(posedge CLK);
        #1;
        release dut.word_count_q;
        preload_req = 1'b0;
        chk_en      = 1'b1;
        up_q.push_back(ent(32'h7777_0001, 32'h7777_0002, 32'h7777_0003));
        drive_up();
        cyc();                       // pop edge
        @(negedge CLK);
        chk32("wrap_start", wc, 32'hFFFF_FFFE);
        step();
        @(negedge CLK);
        chk32("wrap_ff", wc, 32'hFFFF_FFFF);
        step();
        @(negedge CLK);
        chk32("wrap_0", wc, 32'h0000_0000);
        step();
        @(negedge CLK);
        chk32("wrap_1", wc, 32'h0000_0001);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
